// File: rtl/quad_decoder_pkg.sv
// Shared quadrature decoder definitions: FSM states, direction encoding and
// the Gray-code transition lookup reusable by any quadrature model.
package quad_decoder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } qd_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Flops between the pin and the first history entry.
  localparam int SYNC_STAGES = 2;

  // Returns {legal, up} for a move old_ab -> new_ab ({A,B} each).
  // Up order is 00->10->11->01->00; both bits changing is illegal.
  function automatic logic [1:0] qd_lookup(input logic [1:0] old_ab,
                                           input logic [1:0] new_ab);
    logic [1:0] r;
    r = 2'b00;
    case ({old_ab, new_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: r = {1'b1, DIR_UP};
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: r = {1'b1, DIR_DOWN};
      default:                                r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side and counter-side signals of the quadrature decoder.
interface quad_decoder_if #(
  parameter int POS_W = 4
);
  logic             qa;
  logic             qb;
  logic             clr;
  logic             clr_err;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic             err;
  logic             valid;

  modport master (output qa, qb, clr, clr_err,
                  input  step, dir, pos, err, valid);
  modport slave  (input  qa, qb, clr, clr_err,
                  output step, dir, pos, err, valid);
endinterface

// File: rtl/quad_decoder_sync_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-deep agreement filter.
// stable_o only asserts once every stage holds a sample taken after reset.
module quad_decoder_sync_filter
  import quad_decoder_pkg::*;
#(
  parameter int W        = 2,
  parameter int FILT_LEN = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic         stable_o,
  output logic [W-1:0] cand_o
);

  localparam int STAGES = SYNC_STAGES + FILT_LEN;

  logic [W-1:0]               s1_q, s2_q;
  logic [FILT_LEN-1:0][W-1:0] h_q, h_d;
  logic [STAGES-1:0]          vld_pipe_q;
  logic                       all_eq;

  // h[0] is the newest sample.
  always_comb begin
    h_d    = h_q;
    h_d[0] = s2_q;
    for (int i = 1; i < FILT_LEN; i++) h_d[i] = h_q[i-1];
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < FILT_LEN; i++)
      if (h_q[i] != h_q[0]) all_eq = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      s2_q       <= '0;
      h_q        <= '0;
      vld_pipe_q <= '0;
    end else begin
      s1_q       <= d_i;
      s2_q       <= s1_q;
      h_q        <= h_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], 1'b1};
    end
  end

  // Reset-cleared history would otherwise look like a stable 00.
  assign stable_o = vld_pipe_q[STAGES-1] & all_eq;
  assign cand_o   = h_q[0];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: filtered phase pair decoded into step/dir pulses,
// a wrap-around position counter and a sticky illegal-transition flag.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int POS_W    = 4,
  parameter int FILT_LEN = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  quad_decoder_if.slave  bus
);

  logic             stable;
  logic [1:0]       cand;
  logic [1:0]       lut;
  logic             moved, acc_step, acc_err;

  qd_state_e        state_q;
  logic [1:0]       f_ab_q;
  logic             step_q, dir_q, err_q, valid_q;
  logic [POS_W-1:0] pos_q;

  quad_decoder_sync_filter #(
    .W        (2),
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .d_i      ({bus.qa, bus.qb}),
    .stable_o (stable),
    .cand_o   (cand)
  );

  assign lut      = qd_lookup(f_ab_q, cand);
  assign moved    = (state_q == ST_TRACK) && stable && (cand != f_ab_q);
  assign acc_step = moved &  lut[1];
  assign acc_err  = moved & ~lut[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      f_ab_q  <= 2'b00;
      step_q  <= 1'b0;
      dir_q   <= DIR_DOWN;
      pos_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        // First stable state is adopted silently, whatever it is.
        ST_INIT: if (stable) begin
          f_ab_q  <= cand;
          valid_q <= 1'b1;
          state_q <= ST_TRACK;
        end
        ST_TRACK: if (moved) begin
          f_ab_q <= cand;
          if (acc_step) begin
            step_q <= 1'b1;
            dir_q  <= lut[0] ? DIR_UP : DIR_DOWN;
          end
        end
        default: state_q <= ST_INIT;
      endcase

      if (bus.clr)
        pos_q <= '0;
      else if (acc_step)
        pos_q <= lut[0] ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

      // A fresh illegal move outranks a coincident clear.
      if (acc_err)
        err_q <= 1'b1;
      else if (bus.clr_err)
        err_q <= 1'b0;
    end
  end

  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.pos   = pos_q;
  assign bus.err   = err_q;
  assign bus.valid = valid_q;

endmodule
